// File: rtl/fb_port_arbiter_if.sv
// fb_port_arbiter_if: video timing, scanout, clear, draw and RAM port signals of the framebuffer arbiter.
interface fb_port_if #(
   parameter int ADDR_W = 17,
   parameter int DATA_W = 8
);
   logic              hblank;
   logic              vblank;
   logic              scan_req;
   logic [ADDR_W-1:0] scan_addr;
   logic              scan_valid;
   logic [DATA_W-1:0] scan_data;
   logic              clear_start;
   logic              clear_busy;
   logic              draw_valid;
   logic [ADDR_W-1:0] draw_addr;
   logic [DATA_W-1:0] draw_data;
   logic              draw_ready;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   modport master (
      input  hblank, vblank, scan_req, scan_addr, clear_start, draw_valid, draw_addr, draw_data, mem_rdata,
      output scan_valid, scan_data, clear_busy, draw_ready, mem_addr, mem_we, mem_wdata
   );
   modport slave (
      output hblank, vblank, scan_req, scan_addr, clear_start, draw_valid, draw_addr, draw_data, mem_rdata,
      input  scan_valid, scan_data, clear_busy, draw_ready, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: fixed-priority scan > clear > draw sharing of one single-port framebuffer RAM.
// FB_BLANK_WRITE_EN: when defined, draw writes are permitted only during hblank|vblank.
module fb_port_arbiter #(
   parameter int ADDR_W    = 17,
   parameter int DATA_W    = 8,
   parameter int FB_WORDS  = 76800,
   parameter int RD_LAT    = 1,
   parameter int CLEAR_VAL = 0
) (
   input logic       clk,
   input logic       reset_n,
   fb_port_if.master bus
);
   typedef enum logic [1:0] {IDLE, CLEAR_WAIT, CLEAR} state_t;
   state_t            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d, mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, scan_data_q, scan_data_d;
   logic              mem_we_q, mem_we_d, scan_valid_q, scan_valid_d;
   logic [RD_LAT:0]   rd_q, rd_d;
   logic              draw_ok, clr_g, draw_g, last;
`ifdef FB_BLANK_WRITE_EN
   assign draw_ok = bus.hblank | bus.vblank;
`else
   assign draw_ok = 1'b1;
`endif
   always_comb begin
      clr_g       = !bus.scan_req && state_q == CLEAR;
      // reset_n gating keeps the combinational ready low while held in reset
      draw_g      = reset_n && !bus.scan_req && state_q == IDLE && bus.draw_valid && draw_ok;
      last        = cnt_q == ADDR_W'(FB_WORDS - 1);
      state_d     = state_q;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE:       state_d = bus.clear_start ? CLEAR_WAIT : IDLE;
         CLEAR_WAIT: begin
            state_d = bus.vblank ? CLEAR : CLEAR_WAIT;
            cnt_d   = '0;
         end
         CLEAR: if (clr_g) begin
            state_d = last ? IDLE : CLEAR;
            cnt_d   = last ? '0 : cnt_q + ADDR_W'(1);
         end
         default:    state_d = IDLE;
      endcase
      mem_addr_d  = bus.scan_req ? bus.scan_addr : clr_g ? cnt_q : draw_g ? bus.draw_addr : mem_addr_q;
      mem_we_d    = clr_g | draw_g;
      mem_wdata_d = clr_g ? DATA_W'(CLEAR_VAL) : draw_g ? bus.draw_data : mem_wdata_q;
      // rd_q[k] marks a read whose address reached the RAM k cycles ago
      rd_d         = {rd_q[RD_LAT-1:0], bus.scan_req};
      scan_valid_d = rd_q[RD_LAT];
      scan_data_d  = rd_q[RD_LAT] ? bus.mem_rdata : scan_data_q;
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
         rd_q         <= '0;
         scan_valid_q <= 1'b0;
         scan_data_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
         rd_q         <= rd_d;
         scan_valid_q <= scan_valid_d;
         scan_data_q  <= scan_data_d;
      end
   assign bus.draw_ready = draw_g;
   assign bus.clear_busy = state_q == CLEAR_WAIT || state_q == CLEAR;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.scan_valid = scan_valid_q;
   assign bus.scan_data  = scan_data_q;
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed vector table plus scan-latency, priority and clear sequences.
module tb_fb_port_arbiter;
   localparam int AW = 17, DW = 8, FBW = 64;
   logic clk = 1'b0, reset_n = 1'b0;
   int checks = 0, failures = 0;
   fb_port_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   fb_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FB_WORDS(FBW), .RD_LAT(1), .CLEAR_VAL(0))
      dut (.clk(clk), .reset_n(reset_n), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [7:0] f(input logic [16:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction
   // RAM model with one cycle read latency; contents are a fixed address pattern
   always @(posedge clk) bus.mem_rdata <= f(bus.mem_addr);
   typedef struct {
      logic sr; logic [16:0] sa; logic dv; logic [16:0] da; logic [7:0] dd; logic hb, vb;
      logic dr, we; logic [16:0] ma; logic [7:0] wd;
   } vec_t;
   vec_t vt[8];
   function automatic vec_t mk(input logic sr, input logic [16:0] sa, input logic dv, input logic [16:0] da,
                               input logic [7:0] dd, input logic hb, input logic vb, input logic dr,
                               input logic we, input logic [16:0] ma, input logic [7:0] wd);
      vec_t v;
      v.sr = sr; v.sa = sa; v.dv = dv; v.da = da; v.dd = dd; v.hb = hb; v.vb = vb;
      v.dr = dr; v.we = we; v.ma = ma; v.wd = wd;
      return v;
   endfunction
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic idle_in;
      bus.hblank = 0; bus.vblank = 0; bus.scan_req = 0; bus.scan_addr = '0; bus.clear_start = 0;
      bus.draw_valid = 0; bus.draw_addr = '0; bus.draw_data = '0;
   endtask
   task automatic sweep(input bit pre);
      int n = 0;
      bit done = 0;
      logic [7:0] q[$];
      bus.clear_start = 1; bus.draw_valid = 1; bus.draw_addr = 17'h300; bus.draw_data = 8'h77;
      bus.hblank = 1; bus.vblank = 0;
      #2 chk("same_cycle_draw_ready", bus.draw_ready, 1);
      tick;
      chk("same_cycle_draw_we", bus.mem_we, 1);
      chk("same_cycle_draw_addr", bus.mem_addr, 17'h300);
      chk("clear_busy_wait", bus.clear_busy, 1);
      bus.clear_start = 0;
      for (int i = 0; i < 5; i++) begin
         #2 chk("wait_draw_blocked", bus.draw_ready, 0);
         tick;
         chk("wait_no_write", bus.mem_we, 0);
         chk("wait_busy", bus.clear_busy, 1);
      end
      bus.vblank = 1;
      for (int c = 0; c < 400 && !done; c++) begin
         bus.scan_req = pre && (c % 2 == 0);
         bus.scan_addr = 17'h200 + 17'(c % 8);
         if (bus.scan_req) q.push_back(f(bus.scan_addr));
         bus.clear_start = pre && c == 20;
         if (pre && c == 30) bus.vblank = 0;
         #2 chk("sweep_draw_blocked", bus.draw_ready, 0);
         tick;
         if (bus.scan_valid) begin
            if (q.size() == 0) chk("sweep_spurious_scan_valid", 1, 0);
            else chk("sweep_scan_data", bus.scan_data, q.pop_front());
         end
         if (bus.mem_we) begin
            chk("clear_addr", bus.mem_addr, 17'(n));
            chk("clear_data", bus.mem_wdata, 0);
            n++;
         end
         chk("sweep_busy", bus.clear_busy, n < FBW);
         done = n == FBW;
      end
      if (!done) chk("sweep_timeout_writes", n, FBW);
      bus.scan_req = 0; bus.clear_start = 0;
      for (int i = 0; i < 4; i++) begin
         tick;
         if (bus.scan_valid) begin
            if (q.size() == 0) chk("drain_spurious_scan_valid", 1, 0);
            else chk("drain_scan_data", bus.scan_data, q.pop_front());
         end
         chk("post_sweep_idle_busy", bus.clear_busy, 0);
      end
      chk("scan_reads_outstanding", q.size(), 0);
      bus.draw_valid = 0;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "timeout");
   end
   initial begin
      vt[0] = mk(0, 17'h0,     0, 17'h0,     8'h00, 0, 0, 0, 0, 17'h0,     8'h00);
      vt[1] = mk(0, 17'h0,     1, 17'h10,    8'h5A, 1, 0, 1, 1, 17'h10,    8'h5A);
      vt[2] = mk(1, 17'h20,    1, 17'h11,    8'h66, 0, 1, 0, 0, 17'h20,    8'h5A);
      vt[3] = mk(1, 17'h30,    0, 17'h0,     8'h00, 0, 0, 0, 0, 17'h30,    8'h5A);
      vt[4] = mk(0, 17'h0,     1, 17'h1FFFF, 8'hFF, 1, 0, 1, 1, 17'h1FFFF, 8'hFF);
      vt[5] = mk(0, 17'h0,     0, 17'h0,     8'h00, 0, 0, 0, 0, 17'h1FFFF, 8'hFF);
      vt[6] = mk(0, 17'h0,     1, 17'h5,     8'h33, 0, 1, 1, 1, 17'h5,     8'h33);
      vt[7] = mk(1, 17'h1FFFF, 1, 17'h6,     8'h44, 1, 1, 0, 0, 17'h1FFFF, 8'h33);
      idle_in();
      for (int i = 0; i < 6; i++) begin
         bus.hblank = 1'($urandom); bus.vblank = 1'($urandom); bus.scan_req = 1'($urandom);
         bus.scan_addr = 17'($urandom); bus.clear_start = 1'($urandom); bus.draw_valid = 1'b1;
         bus.draw_addr = 17'($urandom); bus.draw_data = 8'($urandom);
         @(negedge clk);
         chk("rst_draw_ready", bus.draw_ready, 0);
         chk("rst_scan_valid", bus.scan_valid, 0);
         chk("rst_scan_data", bus.scan_data, 0);
         chk("rst_clear_busy", bus.clear_busy, 0);
         chk("rst_mem_addr", bus.mem_addr, 0);
         chk("rst_mem_we", bus.mem_we, 0);
         chk("rst_mem_wdata", bus.mem_wdata, 0);
      end
      idle_in();
      @(negedge clk) reset_n = 1;
      tick;
      chk("post_rst_mem_we", bus.mem_we, 0);
      chk("post_rst_busy", bus.clear_busy, 0);
      for (int i = 0; i < 8; i++) begin
         bus.scan_req = vt[i].sr; bus.scan_addr = vt[i].sa; bus.draw_valid = vt[i].dv;
         bus.draw_addr = vt[i].da; bus.draw_data = vt[i].dd; bus.hblank = vt[i].hb; bus.vblank = vt[i].vb;
         #2 chk($sformatf("vec%0d_draw_ready", i), bus.draw_ready, vt[i].dr);
         tick;
         chk($sformatf("vec%0d_mem_we", i), bus.mem_we, vt[i].we);
         chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vt[i].ma);
         chk($sformatf("vec%0d_mem_wdata", i), bus.mem_wdata, vt[i].wd);
      end
      idle_in();
      tick; tick; tick;
      bus.scan_req = 1; bus.scan_addr = 17'h00123;
      tick;
      chk("scan_mem_addr", bus.mem_addr, 17'h00123);
      chk("scan_valid_n1", bus.scan_valid, 0);
      bus.scan_req = 0;
      tick;
      chk("scan_valid_n2", bus.scan_valid, 0);
      tick;
      chk("scan_valid_n3", bus.scan_valid, 1);
      chk("scan_data_n3", bus.scan_data, f(17'h00123));
      tick;
      chk("scan_valid_n4", bus.scan_valid, 0);
      for (int i = 0; i < 13; i++) begin
         bus.scan_req = i < 8;
         bus.scan_addr = 17'h200 + 17'(i);
         tick;
         chk($sformatf("burst_valid_%0d", i), bus.scan_valid, i >= 2 && i <= 9);
         if (i >= 2 && i <= 9) chk($sformatf("burst_data_%0d", i), bus.scan_data, f(17'h200 + 17'(i - 2)));
      end
      idle_in();
      bus.scan_req = 1; bus.scan_addr = 17'h40; bus.draw_valid = 1; bus.draw_addr = 17'h41;
      bus.draw_data = 8'h9C; bus.hblank = 1;
      for (int i = 0; i < 4; i++) begin
         #2 chk("prio_draw_ready_blocked", bus.draw_ready, 0);
         tick;
         chk("prio_no_write", bus.mem_we, 0);
      end
      bus.scan_req = 0;
      #2 chk("prio_draw_ready_after", bus.draw_ready, 1);
      tick;
      chk("prio_we", bus.mem_we, 1);
      chk("prio_addr", bus.mem_addr, 17'h41);
      chk("prio_data", bus.mem_wdata, 8'h9C);
      idle_in();
      tick;
      sweep(0);
      idle_in();
      tick;
      sweep(1);
      idle_in();
      tick;
      bus.draw_valid = 1; bus.draw_addr = 17'h55; bus.draw_data = 8'h12;
      #2;
`ifdef FB_BLANK_WRITE_EN
      chk("blank_active_draw_ready", bus.draw_ready, 0);
      tick;
      chk("blank_active_no_write", bus.mem_we, 0);
      bus.hblank = 1;
      #2 chk("blank_hblank_draw_ready", bus.draw_ready, 1);
`else
      chk("anytime_draw_ready", bus.draw_ready, 1);
`endif
      tick;
      chk("final_draw_we", bus.mem_we, 1);
      chk("final_draw_addr", bus.mem_addr, 17'h55);
      idle_in();
      tick;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
